// File: rtl/alu_exec_sequencer.sv
// Execute-stage sequencer: accepts one ALU instruction per handshake, feeds operands
// from the internal register file to the ALU and retires the registered result.
`ifndef ALU_WIDTH
`define ALU_WIDTH 16
`endif
`ifndef ALU_OPS
`define ALU_OPS 16
`endif
`ifndef CPU_STATES
`define CPU_STATES 4
`endif
`ifndef IDLE
`define IDLE 0
`endif
`ifndef EXECUTE1
`define EXECUTE1 1
`endif
`ifndef EXECUTE2
`define EXECUTE2 2
`endif
`ifndef WRITEBACK
`define WRITEBACK 3
`endif

module alu_exec_sequencer #(
  parameter int ALU_WIDTH = `ALU_WIDTH,
  parameter int NUM_REGS  = 8,
  localparam int RW  = $clog2(NUM_REGS),
  localparam int OPW = $clog2(`ALU_OPS),
  localparam int SW  = $clog2(`CPU_STATES)
) (
  input  logic                 sys_clk,
  input  logic                 sys_reset,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [OPW-1:0]       instr_op,
  input  logic [RW-1:0]        instr_rd,
  input  logic [RW-1:0]        instr_rs1,
  input  logic [RW-1:0]        instr_rs2,
  input  logic                 instr_use_imm,
  input  logic [ALU_WIDTH-1:0] instr_imm,
  output logic [SW-1:0]        cpu_state,
  output logic [ALU_WIDTH-1:0] A_bus,
  output logic [ALU_WIDTH-1:0] B_bus,
  output logic                 alu_en_A_reg,
  output logic                 alu_en_B_reg,
  output logic [OPW-1:0]       alu_op,
  input  logic [ALU_WIDTH-1:0] alu_result,
  input  logic                 cc_greater,
  input  logic                 cc_equal,
  output logic                 flag_gt,
  output logic                 flag_eq,
  output logic                 done,
  output logic                 illegal,
  input  logic [RW-1:0]        dbg_addr,
  output logic [ALU_WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_EX1, S_EX2, S_WB} state_t;

  state_t state, state_nxt;

  logic [ALU_WIDTH-1:0] rf [NUM_REGS];
  logic [OPW-1:0]       op_q;
  logic [RW-1:0]        rd_q;
  logic [ALU_WIDTH-1:0] opa_q, opb_q;
  logic                 ill_q;
  logic [ALU_WIDTH-1:0] rs1_val, rs2_val;

  // r0 is hardwired to zero on every read port
  assign rs1_val  = (instr_rs1 == '0) ? '0 : rf[instr_rs1];
  assign rs2_val  = (instr_rs2 == '0) ? '0 : rf[instr_rs2];
  assign dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (instr_valid) state_nxt = S_EX1;
      S_EX1:   state_nxt = S_EX2;
      S_EX2:   state_nxt = S_WB;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready  = 1'b0;
    cpu_state    = SW'(`IDLE);
    alu_en_A_reg = 1'b0;
    alu_en_B_reg = 1'b0;
    done         = 1'b0;
    illegal      = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = !sys_reset;
        cpu_state   = SW'(`IDLE);
      end
      S_EX1: begin
        cpu_state    = SW'(`EXECUTE1);
        alu_en_A_reg = !ill_q;
        alu_en_B_reg = !ill_q;
      end
      S_EX2: begin
        cpu_state    = SW'(`EXECUTE2);
        alu_en_A_reg = !ill_q;
        alu_en_B_reg = !ill_q;
      end
      default: begin
        cpu_state = SW'(`WRITEBACK);
        done      = 1'b1;
        illegal   = ill_q;
      end
    endcase
  end

  // Buses and opcode simply hold the latched operands between instructions
  assign A_bus  = opa_q;
  assign B_bus  = opb_q;
  assign alu_op = op_q;

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      ill_q   <= 1'b0;
      flag_gt <= 1'b0;
      flag_eq <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            op_q  <= instr_op;
            rd_q  <= instr_rd;
            opa_q <= rs1_val;
            opb_q <= instr_use_imm ? instr_imm : rs2_val;
            ill_q <= (instr_op > OPW'(9));
          end
        end
        S_WB: begin
          if (!ill_q) begin
            if (op_q == OPW'(9)) begin
              flag_gt <= cc_greater;
              flag_eq <= cc_equal;
            end else if (op_q != '0 && rd_q != '0) begin
              rf[rd_q] <= alu_result;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_exec_sequencer.md
# alu_exec_sequencer

Execute-stage sequencer that drives the ALU interface from the controller side. It accepts one decoded ALU instruction per valid/ready handshake and reads operands from an internal register file. It steps `cpu_state` through the execute states, presents operands on `A_bus`/`B_bus` with the ALU load enables, and captures the registered ALU result into the destination register. Compare results are latched into architectural flags for later branch use.

## Interface
- `ALU_WIDTH`, default `` `ALU_WIDTH `` — datapath width.
- `NUM_REGS`, default 8 — register file depth; must be a power of 2. `RW = $clog2(NUM_REGS)`.

Ports:
- `sys_clk`  in  1  — single clock.
- `sys_reset`  in  1  — asynchronous, active-high reset.
- `instr_valid`  in  1  — instruction offered.
- `instr_ready`  out  1  — sequencer can accept.
- `instr_op`  in  `$clog2(`ALU_OPS)`  — ALU opcode (0 nop, 1 add, 2 sub, 3 or, 4 and, 5 not, 6 lsl, 7 lsr, 8 asr, 9 cmp).
- `instr_rd`, `instr_rs1`, `instr_rs2`  in  `RW`  — destination and source register indices.
- `instr_use_imm`  in  1  — B operand comes from `instr_imm` instead of `rs2`.
- `instr_imm`  in  `ALU_WIDTH`  — immediate operand.
- `cpu_state`  out  `$clog2(`CPU_STATES)`  — execute-phase state seen by the ALU.
- `A_bus`, `B_bus`  out  `ALU_WIDTH`  — operands.
- `alu_en_A_reg`, `alu_en_B_reg`  out  1  — ALU operand-load enables.
- `alu_op`  out  `$clog2(`ALU_OPS)`  — opcode to the ALU.
- `alu_result`  in  `ALU_WIDTH`  — registered ALU result.
- `cc_greater`, `cc_equal`  in  1  — registered compare outputs.
- `flag_gt`, `flag_eq`  out  1  — architectural compare flags.
- `done`  out  1  — one-cycle retire pulse.
- `illegal`  out  1  — one-cycle pulse, coincident with `done`, for opcodes 10–15.
- `dbg_addr`  in  `RW`; `dbg_data`  out  `ALU_WIDTH`  — combinational register-file read port.

## Operation
- FSM states are IDLE, EX1, EX2 and WB. `cpu_state` is driven as follows:
  - `` `IDLE `` in IDLE.
  - `` `EXECUTE1 `` in EX1.
  - `` `EXECUTE2 `` in EX2.
  - `` `WRITEBACK `` in WB.
  - All four encodings are defined in `defines.vh`.
- IDLE:
  - `instr_ready`=1.
  - On `instr_valid && instr_ready`, latch op and rd.
  - Latch opA=`reg[rs1]`.
  - Latch opB=`instr_use_imm ? instr_imm : reg[rs2]`.
  - Flag illegal if op>9. Go to EX1.
- EX1: `instr_ready`=0. `A_bus`=opA, `B_bus`=opB, `alu_op`=op. Both enables=1 unless illegal. Go to EX2.
- EX2: Same outputs as EX1; the ALU registers the result at the end of this cycle. Go to WB.
- WB:
  - Enables=0. `done`=1; `illegal`=1 if the op was illegal.
  - Ops 1–8 with rd≠0: `reg[rd]` <= `alu_result`.
  - Op 9: `flag_gt` <= `cc_greater`, `flag_eq` <= `cc_equal`; no register write.
  - Op 0 and illegal ops: no write, flags unchanged.
  - Go to IDLE.
- r0 reads as 0 and writes to it are discarded.
- Flags hold their value until the next cmp.
- Operands are sampled at acceptance. WB completes before the next IDLE read, so no forwarding is needed.
- Outside EX1/EX2: buses are held at the last operands; `alu_op` is held.
- Widths: all operands are full `ALU_WIDTH`; there is no sign or zero extension.

## Timing
- Accept at the edge ending cycle N. EX1 is cycle N+1, EX2 is N+2, WB (`done`) is N+3.
- The written value is visible on `dbg_data` from N+4. `instr_ready` is high again in N+4.
- Throughput: one instruction per 4 cycles minimum.
- Back-to-back dependent instructions read the updated value with no stall.
- `instr_valid` held high while busy: no accept until IDLE; exactly one accept per IDLE cycle.
- Reset (asynchronous) values:
  - State IDLE, all registers 0.
  - `flag_gt`=`flag_eq`=0, `done`=`illegal`=0.
  - Enables 0, buses 0, `alu_op` 0, `cpu_state`=`` `IDLE ``.
  - `instr_ready` is 0 while `sys_reset` is asserted and 1 in the first cycle after deassertion.
- Reset mid-operation: abort immediately with no writeback and no `done`. The ALU shares `sys_reset` and clears alongside.

## Test plan
- **Arithmetic chain.** Reset, then add r1=r0+imm 5, add r2=r0+imm 3, sub r3=r1−r2. Required: r3=2, `done` at N+3 for each instruction, r3 visible at N+4.
- **Compare.** cmp r1,r2 → `flag_gt`=1, `flag_eq`=0, registers unchanged. cmp r2,r2 → gt=0, eq=1. A following add leaves the flags unchanged.
- **r0 and shifts.** add r0=r0+imm 0xFF → r0 still reads 0. lsl r4=r1<<imm 2 → r4=20.
- **Handshake.** Hold `instr_valid` high with 3 queued dependent adds. Required: `instr_ready` low in EX1–WB, accepts exactly 4 cycles apart, final value correct.
- **Illegal opcode.** op 0xC → `illegal` and `done` pulse in WB, ALU enables stay 0 throughout, no register or flag change.
- **Reset mid-operation.** Assert `sys_reset` during EX2 of add r5=imm 7 → outputs reset immediately, r5=0 afterward, no `done`.
